// File: rtl/ahb3lite_sram_arbiter.sv
// ahb3lite_sram_arbiter
//   Two-requester AHB3-Lite master. It shares one ahb3lite_sram1rw slave
//   between two valid/ready command ports using round-robin arbitration.
//   Each granted command becomes a single NONSEQ transfer (no pipelining).
//   The FSM runs IDLE -> ADDR -> DATA -> IDLE. Each response is a registered
//   one-cycle pulse, issued the cycle after the data phase completes.
//
// Ports
//   HCLK, HRESETn                clock, synchronous active-low reset
//   reqN_valid/ready/write/addr/size/wdata   command port N (N = 0, 1);
//                                reqN_ready is a one-cycle accept pulse
//   respN_valid/rdata/err        completion pulse, read data and error flag
//   HSEL..HREADY                 AHB3-Lite master outputs (HREADY = HREADYOUT)
//   HREADYOUT, HRESP, HRDATA     slave response
//   timeout                      sticky watchdog flag
//
// Optional feature: define AHB_ARB_TIMEOUT_EN to add a wait-state watchdog.
// The watchdog bounds HREADYOUT=0 stalls to TIMEOUT_CYCLES. When it expires,
// the arbiter returns an error response and sets the sticky timeout flag.
// When the macro is undefined, timeout is tied to 0.

module ahb3lite_sram_arbiter #(
  parameter int HADDR_SIZE     = 32,
  parameter int HDATA_SIZE     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_write,
  input  logic [HADDR_SIZE-1:0] req0_addr,
  input  logic [2:0]            req0_size,
  input  logic [HDATA_SIZE-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_write,
  input  logic [HADDR_SIZE-1:0] req1_addr,
  input  logic [2:0]            req1_size,
  input  logic [HDATA_SIZE-1:0] req1_wdata,
  output logic                  resp0_valid,
  output logic [HDATA_SIZE-1:0] resp0_rdata,
  output logic                  resp0_err,
  output logic                  resp1_valid,
  output logic [HDATA_SIZE-1:0] resp1_rdata,
  output logic                  resp1_err,
  output logic                  HSEL,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic [HDATA_SIZE-1:0] HWDATA,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic [1:0]            HTRANS,
  output logic                  HREADY,
  input  logic                  HREADYOUT,
  input  logic                  HRESP,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  output logic                  timeout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef struct packed {
    logic                  write;
    logic [2:0]            size;
    logic [HADDR_SIZE-1:0] addr;
    logic [HDATA_SIZE-1:0] wdata;
  } cmd_t;

  cmd_t [1:0]            req_cmd;
  logic [1:0]            req_valid;
  logic [1:0]            state;
  logic                  prio;
  logic                  gnt;
  logic                  accept;
  cmd_t                  cmd;
  logic                  owner;
  logic                  err_seen;   // first ERROR cycle seen in this data phase
  logic [1:0]            resp_valid;
  logic [HDATA_SIZE-1:0] resp_rdata;
  logic                  resp_err;

  assign req_valid  = {req1_valid, req0_valid};
  assign req_cmd[0] = '{write: req0_write, size: req0_size, addr: req0_addr, wdata: req0_wdata};
  assign req_cmd[1] = '{write: req1_write, size: req1_size, addr: req1_addr, wdata: req1_wdata};

  // A lone requester wins outright. When both are valid, prio decides.
  assign gnt    = (req_valid == 2'b10) ? 1'b1 :
                  (req_valid == 2'b01) ? 1'b0 : prio;
  // Gated by reset so no accept can be seen while reset is held.
  assign accept = HRESETn && (state == ST_IDLE) && (|req_valid);

  assign req0_ready = accept && !gnt;
  assign req1_ready = accept &&  gnt;

  assign resp0_valid = resp_valid[0];
  assign resp1_valid = resp_valid[1];
  assign resp0_rdata = resp_rdata;
  assign resp1_rdata = resp_rdata;
  assign resp0_err   = resp_err;
  assign resp1_err   = resp_err;

  assign HSEL   = (state == ST_ADDR);
  assign HTRANS = (state == ST_ADDR) ? 2'b10 : 2'b00;
  assign HADDR  = cmd.addr;
  assign HWRITE = cmd.write;
  assign HSIZE  = cmd.size;
  assign HWDATA = cmd.wdata;
  assign HBURST = 3'b000;
  assign HPROT  = 4'b0011;
  assign HREADY = HREADYOUT;

`ifdef AHB_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;
  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state      <= ST_IDLE;
      prio       <= 1'b0;
      cmd        <= '0;
      owner      <= 1'b0;
      err_seen   <= 1'b0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
`ifdef AHB_ARB_TIMEOUT_EN
      wd_cnt     <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      resp_valid <= '0;
      case (state)
        ST_IDLE: if (|req_valid) begin
          cmd      <= req_cmd[gnt];
          owner    <= gnt;
          prio     <= ~gnt;
          err_seen <= 1'b0;
          state    <= ST_ADDR;
        end
        ST_ADDR: if (HREADYOUT) state <= ST_DATA;
        ST_DATA: begin
          if (HREADYOUT) begin
            resp_valid[owner] <= 1'b1;
            resp_err          <= HRESP | err_seen;
            resp_rdata        <= (HRESP | err_seen | cmd.write) ? '0 : HRDATA;
            state             <= ST_IDLE;
          end else if (HRESP) begin
            err_seen <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef AHB_ARB_TIMEOUT_EN
      // The count restarts on entry to ADDR (from IDLE) and on entry to DATA.
      // An expiry overrides the case above and abandons the transfer.
      if (state == ST_IDLE || (state == ST_ADDR && HREADYOUT)) begin
        wd_cnt <= '0;
      end else if (!HREADYOUT) begin
        if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
          resp_valid[owner] <= 1'b1;
          resp_err          <= 1'b1;
          resp_rdata        <= '0;
          timeout_q         <= 1'b1;
          wd_cnt            <= '0;
          state             <= ST_IDLE;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_ahb3lite_sram_arbiter.sv
// Bench for ahb3lite_sram_arbiter.
//
// A behavioural SRAM slave answers the AHB side. It inserts wait states and
// answers addresses with bit 8 set using a two-cycle ERROR. A reference model
// (a word array plus a round-robin priority bit) computes each expected
// response when the command is accepted, and pushes it into a per-requester
// queue. A monitor pops and compares whenever a respN_valid pulse appears.

module tb_ahb3lite_sram_arbiter;
  localparam int TO = 8;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic [2:0]  req0_size, req1_size;
  logic        resp0_valid, resp0_err, resp1_valid, resp1_err;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic        HSEL, HWRITE, HREADY, HREADYOUT, HRESP, timeout;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;

  ahb3lite_sram_arbiter #(.HADDR_SIZE(32), .HDATA_SIZE(32), .TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_size(req0_size), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_size(req1_size), .req1_wdata(req1_wdata),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .timeout(timeout)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_m [64];   // reference model memory
  logic [31:0] mem_s [64];   // slave's own storage
  logic        prio_m;
  int          last_lat [2];
  int          last_done_cyc;
  int          last_done_owner;
  // environment knobs
  int          max_wait = 0;
  int          force_wait = -1;
  logic        stuck = 1'b0;
  logic        expect_timeout = 1'b0;
  // slave / in-flight state
  logic        dp_active = 1'b0;
  logic        dp_err, dp_w;
  int          dp_wait, dp_k;
  logic [5:0]  dp_idx;
  logic        infl_owner, infl_write;
  logic [31:0] infl_addr, infl_wdata;
  logic [2:0]  infl_size;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_resp(input int n);
    exp_t e;
    logic [31:0] rd;
    logic        er;
    rd = n ? resp1_rdata : resp0_rdata;
    er = n ? resp1_err : resp0_err;
    if ((n ? q1.size() : q0.size()) == 0) begin
      chk($sformatf("resp%0d_unexpected", n), 1, 0);
    end else begin
      e = n ? q1.pop_front() : q0.pop_front();
      chk($sformatf("resp%0d_rdata", n), rd, e.rdata);
      chk($sformatf("resp%0d_err", n), er, e.err);
      if (expect_timeout) chk("timeout_latency", cyc, e.acc + 1 + TO);
      else begin
        chk($sformatf("resp%0d_timing", n), cyc, last_done_cyc + 1);
        chk($sformatf("resp%0d_owner", n), last_done_owner, n);
      end
      last_lat[n] = cyc - e.acc;
    end
  endtask

  // Monitor, scoreboard and slave share one negedge process, so the order
  // within a cycle is fixed: accepts, then responses, then the slave.
  initial begin
    logic g;
    exp_t e;
    logic [5:0] idx;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        q0.delete(); q1.delete();
        dp_active = 1'b0; prio_m = 1'b0;
        HREADYOUT = 1'b1; HRESP = 1'b0;
      end else begin
        if (req0_ready || req1_ready) begin
          chk("ready_onehot", {31'b0, req0_ready && req1_ready}, 0);
          g = req1_ready;
          chk("ready_without_valid", {31'b0, g ? req1_valid : req0_valid}, 1);
          if (req0_valid && req1_valid) chk("rr_grant", {31'b0, g}, {31'b0, prio_m});
          prio_m     = !g;
          infl_owner = g;
          infl_write = g ? req1_write : req0_write;
          infl_addr  = g ? req1_addr : req0_addr;
          infl_wdata = g ? req1_wdata : req0_wdata;
          infl_size  = g ? req1_size : req0_size;
          idx        = infl_addr[7:2];
          e.acc      = cyc;
          e.rdata    = 32'h0;
          e.err      = 1'b0;
          if (expect_timeout || infl_addr[8]) e.err = 1'b1;
          else if (infl_write) mem_m[idx] = infl_wdata;
          else e.rdata = mem_m[idx];
          if (g) q1.push_back(e); else q0.push_back(e);
        end
        if (resp0_valid) check_resp(0);
        if (resp1_valid) check_resp(1);
        // slave data phase
        HRDATA = $urandom;
        if (dp_active) begin
          chk("htrans_in_data", HTRANS, 0);
          if (dp_w) chk("hwdata_hold", HWDATA, infl_wdata);
          if (dp_k < dp_wait) begin
            HREADYOUT = 1'b0; HRESP = 1'b0;
          end else if (dp_err && dp_k == dp_wait) begin
            HREADYOUT = 1'b0; HRESP = 1'b1;
          end else begin
            HREADYOUT = 1'b1; HRESP = dp_err;
            if (!dp_err) begin
              if (dp_w) mem_s[dp_idx] = HWDATA;
              else HRDATA = mem_s[dp_idx];
            end
            dp_active       = 1'b0;
            last_done_cyc   = cyc;
            last_done_owner = int'(infl_owner);
          end
          dp_k++;
        end else begin
          HREADYOUT = !stuck; HRESP = 1'b0;
        end
        // slave address phase
        if (HSEL && HTRANS == 2'b10) begin
          chk("no_pipelining", {31'b0, dp_active}, 0);
          chk("haddr", HADDR, infl_addr);
          chk("hwrite", {31'b0, HWRITE}, {31'b0, infl_write});
          chk("hsize", HSIZE, infl_size);
          chk("hburst", HBURST, 0);
          chk("hprot", HPROT, 4'b0011);
          if (HREADYOUT) begin
            dp_active = 1'b1; dp_k = 0;
            dp_wait = (force_wait >= 0) ? force_wait : $urandom_range(0, max_wait);
            dp_err  = HADDR[8];
            dp_w    = HWRITE;
            dp_idx  = HADDR[7:2];
          end
        end
      end
    end
  end

  task automatic drive(input int n, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] sz);
    logic ok;
    if (n == 0) begin
      req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d; req0_size = sz;
    end else begin
      req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d; req1_size = sz;
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge HCLK);
      if (n == 0 ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge HCLK); #1;
    if (n == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    chk($sformatf("grant_wait%0d", n), {31'b0, ok}, 1);
  endtask

  task automatic rnd_drive(input int n);
    logic [31:0] a;
    a = (32'($urandom_range(0, 63)) << 2) | (($urandom_range(0, 7) == 0) ? 32'h100 : 32'h0);
    drive(n, 1'($urandom_range(0, 1)), a, $urandom, 3'd2);
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge HCLK);
      if (q0.size() == 0 && q1.size() == 0 && !dp_active) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", {31'b0, ok}, 1);
    @(posedge HCLK); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_resp0_valid", {31'b0, resp0_valid}, 0);
    chk("rst_resp1_valid", {31'b0, resp1_valid}, 0);
    chk("rst_ready", {30'b0, req1_ready, req0_ready}, 0);
    chk("rst_hsel", {31'b0, HSEL}, 0);
    chk("rst_htrans", HTRANS, 0);
    chk("rst_haddr", HADDR, 0);
    chk("rst_hwdata", HWDATA, 0);
    chk("rst_hwrite", {31'b0, HWRITE}, 0);
    chk("rst_hsize", HSIZE, 0);
    chk("rst_timeout", {31'b0, timeout}, 0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem_m[i] = 32'h0;
      mem_s[i] = 32'h0;
    end
    {req0_valid, req0_write, req0_addr, req0_wdata, req0_size} = '0;
    {req1_valid, req1_write, req1_addr, req1_wdata, req1_size} = '0;
    HREADYOUT = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    HRESETn = 1'b0;

    // Both requesters valid from reset: req0 wins first, then req1.
    fork
      drive(0, 1'b1, 32'h0, 32'hA, 3'd2);
      drive(1, 1'b1, 32'h4, 32'hB, 3'd2);
      begin
        repeat (3) @(posedge HCLK); #1;
        chk_reset_outputs();
        HRESETn = 1'b1;
      end
    join
    wait_idle();
    drive(1, 1'b0, 32'h4, 32'h0, 3'd2);
    drive(0, 1'b0, 32'h0, 32'h0, 3'd2);
    wait_idle();

    // Word write then read at 0x10 with no wait states: 3-cycle latency.
    drive(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
    wait_idle();
    chk("write_latency", last_lat[0], 3);
    drive(0, 1'b0, 32'h10, 32'h0, 3'd2);
    wait_idle();
    chk("read_latency", last_lat[0], 3);

    // Four data-phase wait states on a write, followed by a read-back.
    force_wait = 4;
    drive(1, 1'b1, 32'h24, 32'h12345678, 3'd2);
    wait_idle();
    chk("wait_latency", last_lat[1], 7);
    force_wait = -1;
    drive(0, 1'b0, 32'h24, 32'h0, 3'd2);
    wait_idle();

    // Two-cycle ERROR response on a read.
    drive(1, 1'b0, 32'h108, 32'h0, 3'd2);
    wait_idle();
    chk("err_latency", last_lat[1], 4);
    chk("idle_after_err", {30'b0, HTRANS}, 0);

    // Reset pulse during the data phase of a req0 read: that read is dropped.
    force_wait = 20;
    drive(0, 1'b0, 32'h10, 32'h0, 3'd2);
    begin
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge HCLK);
        if (dp_active) begin
          ok = 1'b1;
          break;
        end
      end
      chk("reach_data_phase", {31'b0, ok}, 1);
    end
    @(posedge HCLK); #1 HRESETn = 1'b0;
    @(posedge HCLK); #1;
    chk_reset_outputs();
    HRESETn = 1'b1;
    force_wait = -1;
    repeat (4) @(posedge HCLK); #1;
    drive(1, 1'b0, 32'h10, 32'h0, 3'd2);
    wait_idle();

    // Randomized traffic from both requesters, with waits and errors.
    max_wait = 3;
    fork
      begin
        for (int i = 0; i < 50; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge HCLK);
          #1 rnd_drive(0);
        end
      end
      begin
        for (int j = 0; j < 50; j++) begin
          repeat ($urandom_range(0, 3)) @(posedge HCLK);
          #1 rnd_drive(1);
        end
      end
    join
    wait_idle();
    max_wait = 0;
    for (int i = 0; i < 64; i += 9) begin
      drive(i % 2, 1'b0, 32'(i) << 2, 32'h0, 3'd2);
    end
    wait_idle();

`ifdef AHB_ARB_TIMEOUT_EN
    stuck = 1'b1; expect_timeout = 1'b1;
    drive(0, 1'b1, 32'h30, 32'hCAFEF00D, 3'd2);
    wait_idle();
    chk("timeout_set", {31'b0, timeout}, 1);
    stuck = 1'b0; expect_timeout = 1'b0;
    drive(1, 1'b0, 32'h30, 32'h0, 3'd2);
    wait_idle();
    chk("timeout_sticky", {31'b0, timeout}, 1);
`else
    chk("timeout_tied_low", {31'b0, timeout}, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute safety net in case a handshake wait logic itself stalls.
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit reached");
  end
endmodule
